spi_status_tx: RTL and testbench
================================

# spi_status_tx

Transmit side of the host SPI link: drives `spi_miso` back to the host MCU while it clocks command bytes into `spi_driver`. On every chip-select assertion it snapshots renderer status (sprite queue occupancy, frame counter, flags) and shifts out a fixed 32-bit status frame, MSB first, SPI mode 0. It sits beside `spi_driver` in `top`, shares the SPI pins, and runs on the system `clock`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `spi_cs`/`spi_clk`/`global_vsync`.
- `MAGIC`, 8'hA5: first byte of every frame.
- `FRAME_BITS`, 32: bits per status frame.

Ports:
- `clock` in 1: system clock. Only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_cs` in 1: host chip select, active low, asynchronous to `clock`.
- `spi_clk` in 1: host SPI clock, asynchronous to `clock`.
- `spi_miso` out 1: serial status data.
- `spi_miso_oe` out 1: output enable for the MISO pad; 1 only while selected.
- `global_vsync` in 1: frame sync from the screen driver.
- `queue_count` in 8: current sprite draw queue occupancy.
- `queue_full`, `queue_empty` in 1 each: queue flags.
- `fb_resetting` in 1: framebuffer clear in progress.
- `overflow_pulse` in 1: one-cycle pulse when an enqueue was dropped.
- `frame_count` out 8: free-running vsync counter (also sent in frame).
- `tx_busy` out 1: high in LOAD/SHIFT.

## Operation
- Frame layout, MSB first: [31:24] `MAGIC`; [23:16] `queue_count`; [15:8] `frame_count`; [7:0] flags = {`fb_resetting`, `queue_full`, `queue_empty`, `overflow_sticky`, 4'b0000}.
- `frame_count` increments (mod 256, wraps 255->0) on each synchronized rising edge of `global_vsync`.
- `overflow_sticky` set by `overflow_pulse`; cleared when a frame's 32nd bit is shifted out. Set and clear in same cycle: set wins.
- FSM:
  - IDLE: `spi_miso_oe`=0, `spi_miso`=0. Synchronized CS falling edge -> LOAD.
  - LOAD (1 cycle): snapshot frame into shift register, bit counter=0, `spi_miso`=bit 31, `spi_miso_oe`=1 -> SHIFT.
  - SHIFT: on each synchronized `spi_clk` falling edge, shift left, counter+1, `spi_miso`=new MSB. When counter reaches `FRAME_BITS`: clear sticky, reload a fresh snapshot (back-to-back frames in one CS window), counter=0.
  - CS rising edge in LOAD or SHIFT -> IDLE immediately, partial frame abandoned, sticky not cleared.
- `spi_clk` edges while IDLE are ignored. Rising edges never change `spi_miso` (host samples on rising).

## Timing
- Input sync: `SYNC_STAGES` FFs plus one edge-detect register; pin event -> internal edge = 3 cycles at default.
- CS falling pin -> `spi_miso` valid with bit 31: 4 cycles (sync+edge 3, LOAD 1).
- `spi_clk` falling pin -> next bit on `spi_miso`: 3 cycles.
- Requirement: `spi_clk` high and low phases each >= 4 `clock` cycles; CS fall to first `spi_clk` rise >= 6 cycles.
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `frame_count`=0, `tx_busy`=0, sticky=0, state IDLE, sync chains to idle levels (CS=1, clk=0, vsync=0). Reset mid-frame: outputs drop to reset values asynchronously; no frame resumes until a new CS falling edge after release.

## Structure
- Shared package `kule_spi_pkg`: `MAGIC` default, flag bit positions, `tx_state_t` enum {IDLE, LOAD, SHIFT}.
- Sub-module `sync_edge`: parameterized synchronizer with rise/fall pulse outputs; instantiated three times.

## Test plan
- Reset, CS low, 32 falling edges with `queue_count`=8'h05, empty=0, full=0, `fb_resetting`=0 -> host reads 32'hA5_05_00_00.
- 3 vsync pulses, `queue_count`=8'hFF, `queue_full`=1, then read -> 32'hA5_FF_03_40; `frame_count`=3.
- `overflow_pulse` once, two back-to-back frames in one CS window -> flags 8'h10 then 8'h00.
- `overflow_pulse` coincident with 32nd falling edge -> next frame flags still show bit 4 set.
- CS deasserted after 12 bits -> `spi_miso_oe`=0 within 3 cycles; next CS gives full frame from MAGIC; sticky preserved.
- 256 vsync pulses -> `frame_count` wraps to 0; `reset_n` low mid-SHIFT -> `spi_miso_oe`=0 same cycle, `frame_count`=0.

Source files
------------

// File: rtl/kule_spi_pkg.sv
// Shared definitions for the host SPI link.
// Contents: default frame magic byte, flag byte bit positions, the status
// transmitter state encoding, and helpers that assemble the flag byte and the
// 32-bit status frame.
package kule_spi_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Bit positions inside the flag byte; bits [3:0] are reserved and sent as 0.
  localparam int FLAG_FB_RESETTING = 7;
  localparam int FLAG_QUEUE_FULL   = 6;
  localparam int FLAG_QUEUE_EMPTY  = 5;
  localparam int FLAG_OVERFLOW     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  function automatic logic [7:0] pack_flags(input logic fb_resetting,
                                            input logic queue_full,
                                            input logic queue_empty,
                                            input logic overflow);
    logic [7:0] flags;
    flags                    = 8'h00;
    flags[FLAG_FB_RESETTING] = fb_resetting;
    flags[FLAG_QUEUE_FULL]   = queue_full;
    flags[FLAG_QUEUE_EMPTY]  = queue_empty;
    flags[FLAG_OVERFLOW]     = overflow;
    return flags;
  endfunction

  function automatic logic [31:0] pack_frame(input logic [7:0] magic,
                                             input logic [7:0] queue_count,
                                             input logic [7:0] frame_count,
                                             input logic [7:0] flags);
    return {magic, queue_count, frame_count, flags};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous input.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   din            : asynchronous input pin
//   rise, fall     : one-cycle pulses on a synchronized rising/falling edge
// An event on din shows up on rise/fall after STAGES+1 clock edges.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus the previous-level register used for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_status_tx.sv
// SPI status transmitter: on each chip-select assertion snapshots renderer
// status and shifts a 32-bit frame out on MISO, MSB first, SPI mode 0.
// Ports:
//   clock, reset_n              : system clock, asynchronous active-low reset
//   spi_cs, spi_clk             : host SPI chip select (active low) and clock
//   spi_miso, spi_miso_oe       : serial status data and its pad enable
//   global_vsync                : frame sync, counted into frame_count
//   queue_count/full/empty      : sprite queue status
//   fb_resetting                : framebuffer clear in progress
//   overflow_pulse              : dropped-enqueue pulse, latched until sent
//   frame_count                 : free-running vsync counter
//   tx_busy                     : high while loading or shifting a frame
module spi_status_tx
  import kule_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
  parameter int         FRAME_BITS  = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       spi_cs,
  input  logic       spi_clk,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       global_vsync,
  input  logic [7:0] queue_count,
  input  logic       queue_full,
  input  logic       queue_empty,
  input  logic       fb_resetting,
  input  logic       overflow_pulse,
  output logic [7:0] frame_count,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic                  cs_rise_s, cs_fall_s;
  logic                  clk_rise_s, clk_fall_s;
  logic                  vsync_rise_s, vsync_fall_s;
  logic                  unused_s;
  logic                  frame_done_s;
  logic                  sticky_next_s;
  logic [FRAME_BITS-1:0] snapshot_s;

  tx_state_t             state_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  miso_r;
  logic                  miso_oe_r;
  logic                  busy_r;
  logic                  sticky_r;
  logic [7:0]            frame_count_r;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset_n(reset_n), .din(spi_cs),
    .rise(cs_rise_s), .fall(cs_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clock(clock), .reset_n(reset_n), .din(spi_clk),
    .rise(clk_rise_s), .fall(clk_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_vsync (
    .clock(clock), .reset_n(reset_n), .din(global_vsync),
    .rise(vsync_rise_s), .fall(vsync_fall_s)
  );

  // Host samples on rising SCK and vsync counts rising edges only.
  assign unused_s = clk_rise_s ^ vsync_fall_s;

  // Last bit of a frame leaves on this falling edge unless CS is being dropped.
  assign frame_done_s = (state_r == SHIFT) && clk_fall_s && !cs_rise_s &&
                        (cnt_r == CNT_W'(FRAME_BITS - 1));

  // Sticky overflow: a new pulse wins over the end-of-frame clear.
  always_comb begin
    sticky_next_s = sticky_r;
    if (overflow_pulse) begin
      sticky_next_s = 1'b1;
    end else if (frame_done_s) begin
      sticky_next_s = 1'b0;
    end else begin
      sticky_next_s = sticky_r;
    end
  end

  // Snapshot uses the next sticky value so a back-to-back frame sees the clear.
  assign snapshot_s = FRAME_BITS'(pack_frame(MAGIC, queue_count, frame_count_r,
                        pack_flags(fb_resetting, queue_full, queue_empty, sticky_next_s)));

  // Free-running vsync counter, wraps naturally at 8 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_r <= 8'd0;
    end else if (vsync_rise_s) begin
      frame_count_r <= frame_count_r + 8'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  // Transmit FSM with registered MISO, output enable and busy flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      cnt_r     <= '0;
      miso_r    <= 1'b0;
      miso_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      sticky_r  <= 1'b0;
    end else begin
      sticky_r <= sticky_next_s;
      case (state_r)
        IDLE: begin
          miso_r    <= 1'b0;
          miso_oe_r <= 1'b0;
          if (cs_fall_s) begin
            state_r <= LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        LOAD: begin
          if (cs_rise_s) begin
            state_r   <= IDLE;
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            busy_r    <= 1'b0;
          end else begin
            state_r   <= SHIFT;
            shift_r   <= snapshot_s;
            cnt_r     <= '0;
            miso_r    <= snapshot_s[FRAME_BITS-1];
            miso_oe_r <= 1'b1;
            busy_r    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise_s) begin
            state_r   <= IDLE;
            miso_r    <= 1'b0;
            miso_oe_r <= 1'b0;
            busy_r    <= 1'b0;
          end else if (frame_done_s) begin
            // Still selected: start the next frame from a fresh snapshot.
            shift_r <= snapshot_s;
            cnt_r   <= '0;
            miso_r  <= snapshot_s[FRAME_BITS-1];
          end else if (clk_fall_s) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
            cnt_r   <= cnt_r + CNT_W'(1);
            miso_r  <= shift_r[FRAME_BITS-2];
          end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          miso_r    <= 1'b0;
          miso_oe_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = miso_oe_r;
  assign tx_busy     = busy_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_spi_status_tx.sv
module tb_spi_status_tx;

  logic       clock;
  logic       reset_n;
  logic       spi_cs;
  logic       spi_clk;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       global_vsync;
  logic [7:0] queue_count;
  logic       queue_full;
  logic       queue_empty;
  logic       fb_resetting;
  logic       overflow_pulse;
  logic [7:0] frame_count;
  logic       tx_busy;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [7:0]  fc_model;

  spi_status_tx dut (
    .clock(clock), .reset_n(reset_n), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .global_vsync(global_vsync),
    .queue_count(queue_count), .queue_full(queue_full), .queue_empty(queue_empty),
    .fb_resetting(fb_resetting), .overflow_pulse(overflow_pulse),
    .frame_count(frame_count), .tx_busy(tx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Host shifts n bits: sample MISO when raising SCK, optional overflow
  // pulse aligned with the internal falling edge of the last bit.
  task automatic spi_bits(input int n, input bit ovf_last, output logic [31:0] data);
    data = 32'h0;
    for (int i = 0; i < n; i++) begin
      data    = {data[30:0], spi_miso};
      spi_clk = 1'b1;
      wait_cycles(4);
      spi_clk = 1'b0;
      if (ovf_last && (i == n - 1)) begin
        wait_cycles(2);
        overflow_pulse = 1'b1;
        wait_cycles(1);
        overflow_pulse = 1'b0;
        wait_cycles(1);
      end else begin
        wait_cycles(4);
      end
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_cycles(6);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    wait_cycles(5);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] exp, input bit ovf_last);
    logic [31:0] d;
    exp_q.push_back(exp);
    spi_bits(32, ovf_last, d);
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic vsync_pulse();
    global_vsync = 1'b1;
    wait_cycles(4);
    global_vsync = 1'b0;
    wait_cycles(4);
    fc_model = fc_model + 8'd1;
  endtask

  task automatic ovf_once();
    overflow_pulse = 1'b1;
    wait_cycles(1);
    overflow_pulse = 1'b0;
    wait_cycles(1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; fc_model = 8'd0;
    reset_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b0; global_vsync = 1'b0;
    queue_count = 8'h00; queue_full = 1'b0; queue_empty = 1'b0;
    fb_resetting = 1'b0; overflow_pulse = 1'b0;
    wait_cycles(3);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_fc", {24'd0, frame_count}, 32'd0);
    reset_n = 1'b1;
    wait_cycles(3);

    // Basic frame with latency checks on the CS path.
    queue_count = 8'h05;
    spi_cs = 1'b0;
    wait_cycles(3);
    check("load_busy", {31'd0, tx_busy}, 32'd1);
    check("load_oe_early", {31'd0, spi_miso_oe}, 32'd0);
    wait_cycles(1);
    check("load_oe", {31'd0, spi_miso_oe}, 32'd1);
    check("load_bit31", {31'd0, spi_miso}, 32'd1);
    wait_cycles(2);
    run_frame("frame_basic", 32'hA505_0000, 1'b0);
    cs_high();
    check("idle_busy", {31'd0, tx_busy}, 32'd0);

    // Vsync counting and queue full flag.
    for (int i = 0; i < 3; i++) vsync_pulse();
    check("fc_3", {24'd0, frame_count}, {24'd0, fc_model});
    queue_count = 8'hFF; queue_full = 1'b1;
    cs_low();
    run_frame("frame_full", 32'hA5FF_0340, 1'b0);
    cs_high();

    // Sticky overflow reported once, cleared for the back-to-back frame.
    queue_count = 8'h10; queue_full = 1'b0;
    ovf_once();
    cs_low();
    run_frame("b2b_first", 32'hA510_0310, 1'b0);
    run_frame("b2b_second", 32'hA510_0300, 1'b0);
    cs_high();

    // Overflow coincident with the last falling edge: set wins.
    cs_low();
    run_frame("coinc_first", 32'hA510_0300, 1'b1);
    run_frame("coinc_second", 32'hA510_0310, 1'b0);
    cs_high();

    // Abort after 12 bits; sticky must survive into the next frame.
    ovf_once();
    cs_low();
    exp_q.push_back(32'h0000_0A51);
    spi_bits(12, 1'b0, got);
    check("partial_bits", got, exp_q.pop_front());
    spi_cs = 1'b1;
    wait_cycles(2);
    check("abort_oe_hold", {31'd0, spi_miso_oe}, 32'd1);
    wait_cycles(1);
    check("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    wait_cycles(3);
    cs_low();
    run_frame("after_abort", 32'hA510_0310, 1'b0);
    cs_high();

    // Frame counter wrap.
    for (int i = 0; i < 252; i++) vsync_pulse();
    check("fc_255", {24'd0, frame_count}, {24'd0, fc_model});
    vsync_pulse();
    check("fc_wrap", {24'd0, frame_count}, 32'd0);
    vsync_pulse();
    check("fc_1", {24'd0, frame_count}, 32'd1);

    // Asynchronous reset mid-shift.
    queue_count = 8'h00; queue_empty = 1'b1; fb_resetting = 1'b1;
    cs_low();
    spi_bits(5, 1'b0, got);
    reset_n = 1'b0;
    #1;
    check("arst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("arst_busy", {31'd0, tx_busy}, 32'd0);
    check("arst_fc", {24'd0, frame_count}, 32'd0);
    check("arst_miso", {31'd0, spi_miso}, 32'd0);
    fc_model = 8'd0;
    wait_cycles(2);
    spi_cs = 1'b1;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(4);
    spi_bits(3, 1'b0, got);
    check("idle_sck_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("idle_sck_busy", {31'd0, tx_busy}, 32'd0);
    cs_low();
    run_frame("post_reset", 32'hA500_00A0, 1'b0);
    cs_high();
    check("final_fc", {24'd0, frame_count}, {24'd0, fc_model});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
